multicycle_control: RTL

//  Control FSM sequencing a shared-ALU, shared-memory MIPS multi-cycle datapath.

---
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the shared-ALU / shared-memory MIPS multi-cycle datapath.
// Moore outputs are registered from the next state; only the branch PC load follows zero.
module multicycle_control #(
   parameter bit          HALT_ON_ZERO = 1'b1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic             zero,
   output logic             pc_write,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             zext_imm,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             halted,
   output logic             except,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] inst_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ALU_WB   = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       zext_imm;
      logic [1:0] pc_source;
   } ctl_t;

   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;
   localparam logic [2:0] ALU_XOR = 3'd7;

   state_t cur, nxt;
   ctl_t   ctl_q;
   logic   bad;
   logic   br_take;

   // Returns 3'd0 for an unsupported funct code.
   function automatic logic [2:0] r_op(input logic [5:0] f);
      case (f)
         6'h20:   r_op = ALU_ADD;
         6'h22:   r_op = ALU_SUB;
         6'h24:   r_op = ALU_AND;
         6'h25:   r_op = ALU_OR;
         6'h27:   r_op = ALU_NOR;
         6'h26:   r_op = ALU_XOR;
         default: r_op = 3'd0;
      endcase
   endfunction

   function automatic ctl_t ctl_for(input state_t s, input logic [31:0] ir);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.pc_write  = 1'b1;
            c.ir_write  = 1'b1;
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'd1;
            c.alu_op    = ALU_ADD;
         end
         S_DECODE: begin
            c.alu_src_b = 2'd3;
            c.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = 1'b1;
            c.reg_dst   = 1'b1;
            c.alu_op    = (ir == 32'h0) ? ALU_ADD : r_op(ir[5:0]);
         end
         S_EXEC_I: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            case (ir[31:26])
               6'h0c:   begin c.alu_op = ALU_AND; c.zext_imm = 1'b1; end
               6'h0d:   begin c.alu_op = ALU_OR;  c.zext_imm = 1'b1; end
               6'h0e:   begin c.alu_op = ALU_XOR; c.zext_imm = 1'b1; end
               default: c.alu_op = ALU_ADD;
            endcase
         end
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'd2;
            c.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            c.i_or_d   = 1'b1;
            c.mem_read = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = ALU_SUB;
            c.pc_source = 2'd1;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'd2;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = (ir[31:26] == 6'h00);
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = S_FETCH;
      bad = 1'b0;
      case (cur)
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (inst[31:26])
               6'h00: begin
                  if (inst == 32'h0)
                     nxt = HALT_ON_ZERO ? S_HALT : S_EXEC_R;
                  else if (r_op(inst[5:0]) != 3'd0)
                     nxt = S_EXEC_R;
                  else begin
                     nxt = S_HALT;
                     bad = 1'b1;
                  end
               end
               6'h08, 6'h0c, 6'h0d, 6'h0e: nxt = S_EXEC_I;
               6'h23, 6'h2b:               nxt = S_MEM_ADDR;
               6'h04, 6'h05:               nxt = S_BRANCH;
               6'h02:                      nxt = S_JUMP;
               default: begin
                  nxt = S_HALT;
                  bad = 1'b1;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
         S_MEM_ADDR:         nxt = (inst[31:26] == 6'h2b) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:           nxt = S_MEM_WB;
         S_HALT:             nxt = S_HALT;
         default:            nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur         <= S_FETCH;
         ctl_q       <= ctl_for(S_FETCH, inst);
         halted      <= 1'b0;
         except      <= 1'b0;
         cycle_count <= '0;
         inst_count  <= '0;
      end else begin
         cur    <= nxt;
         ctl_q  <= ctl_for(nxt, inst);
         halted <= (nxt == S_HALT);
         if (bad)
            except <= 1'b1;
         if (cur != S_HALT)
            cycle_count <= cycle_count + CNT_W'(1);
         if (cur inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP})
            inst_count <= inst_count + CNT_W'(1);
      end
   end

   // inst[26] separates bne (0x05) from beq (0x04).
   assign br_take = (cur == S_BRANCH) && (inst[26] ? ~zero : zero);

   // Strobes are masked while reset is high so a write in flight never lands.
   assign pc_write   = ~reset & (ctl_q.pc_write | br_take);
   assign ir_write   = ~reset & ctl_q.ir_write;
   assign mem_read   = ~reset & ctl_q.mem_read;
   assign mem_write  = ~reset & ctl_q.mem_write;
   assign reg_write  = ~reset & ctl_q.reg_write;
   assign i_or_d     = ctl_q.i_or_d;
   assign reg_dst    = ctl_q.reg_dst;
   assign mem_to_reg = ctl_q.mem_to_reg;
   assign alu_src_a  = ctl_q.alu_src_a;
   assign alu_src_b  = ctl_q.alu_src_b;
   assign alu_op     = ctl_q.alu_op;
   assign zext_imm   = ctl_q.zext_imm;
   assign pc_source  = ctl_q.pc_source;
   assign state      = cur;

endmodule
